// File: rtl/serial_adder.sv
// Multi-cycle add/subtract unit: STEP bits per clock through a ripple slice,
// started by a one-cycle request and finished with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | one STEP-bit slice per cycle, N cycles
// DONE  | results just updated, done high; start here chains the next op
module serial_adder #(
  parameter int W    = 32,
  parameter int STEP = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] z,
  output logic         cout,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam int N  = W / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    z_sh;
  logic [W-1:0]    z_next;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [STEP-1:0] sum;
  logic [STEP:0]   c;

  // Ripple slice of 1-bit full adders over the low STEP bits.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = carry;
    for (int i = 0; i < STEP; i++) begin
      sum[i]   = a_sh[i] ^ b_sh[i] ^ c[i];
      c[i+1]   = (a_sh[i] & b_sh[i]) | (c[i] & (a_sh[i] ^ b_sh[i]));
    end
    z_next = (z_sh >> STEP) | (W'(sum) << (W - STEP));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      z_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      z     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b ^ {W{sub}};
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> STEP;
          b_sh  <= b_sh >> STEP;
          z_sh  <= z_next;
          carry <= c[STEP];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Signed overflow: carry into the MSB differs from carry out of it.
            z     <= z_next;
            cout  <= c[STEP];
            ovf   <= c[STEP-1] ^ c[STEP];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three parameterisations (4/1, 8/2,
// 16/16) against an arithmetic reference model, directed and random ops.
module tb_serial_adder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start4, sub4, cin4, cout4, ovf4, busy4, done4;
  logic [3:0]  a4, b4, z4;
  logic        start8, sub8, cin8, cout8, ovf8, busy8, done8;
  logic [7:0]  a8, b8, z8;
  logic        start16, sub16, cin16, cout16, ovf16, busy16, done16;
  logic [15:0] a16, b16, z16;

  serial_adder #(.W(4), .STEP(1)) u_add4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .cin(cin4), .z(z4), .cout(cout4), .ovf(ovf4), .busy(busy4), .done(done4));

  serial_adder #(.W(8), .STEP(2)) u_add8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .cin(cin8), .z(z8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8));

  serial_adder #(.W(16), .STEP(16)) u_add16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .cin(cin16), .z(z16), .cout(cout16), .ovf(ovf16), .busy(busy16), .done(done16));

  int n_vec = 0;
  int n_err = 0;
  int cur = 0;

  logic [31:0] obs_z;
  logic        obs_cout, obs_ovf, obs_busy, obs_done;

  always_comb begin
    obs_z    = '0;
    obs_cout = 1'b0;
    obs_ovf  = 1'b0;
    obs_busy = 1'b0;
    obs_done = 1'b0;
    case (cur)
      0: begin
        obs_z = 32'(z4); obs_cout = cout4; obs_ovf = ovf4; obs_busy = busy4; obs_done = done4;
      end
      1: begin
        obs_z = 32'(z8); obs_cout = cout8; obs_ovf = ovf8; obs_busy = busy8; obs_done = done8;
      end
      default: begin
        obs_z = 32'(z16); obs_cout = cout16; obs_ovf = ovf16; obs_busy = busy16; obs_done = done16;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (inst %0d, t=%0t): got 0x%0h expected 0x%0h", tag, cur, $time, got, exp);
    end
  endtask

  function automatic int w_of(input int inst);
    return (inst == 0) ? 4 : (inst == 1) ? 8 : 16;
  endfunction

  function automatic int n_of(input int inst);
    return (inst == 0) ? 4 : (inst == 1) ? 4 : 1;
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input int inst, input logic s, input logic [31:0] aa, input logic [31:0] bb,
                       input logic ci, output logic [31:0] ez, output logic ec, output logic eo);
    int w;
    longint unsigned span, ua, ub, full;
    longint sa, sb, sv, smax, smin;
    w    = w_of(inst);
    span = 64'd1 << w;
    ua   = longint'(aa) & (span - 1);
    ub   = longint'(bb) & (span - 1);
    if (s) full = ua + span - ub;
    else   full = ua + ub + longint'(ci);
    ez   = 32'(full & (span - 1));
    ec   = ((full >> w) & 1) != 0;
    sa   = (ua >= span / 2) ? longint'(ua) - longint'(span) : longint'(ua);
    sb   = (ub >= span / 2) ? longint'(ub) - longint'(span) : longint'(ub);
    sv   = s ? sa - sb : sa + sb + longint'(ci);
    smax = longint'(span / 2) - 1;
    smin = -longint'(span / 2);
    eo   = (sv > smax) || (sv < smin);
  endtask

  task automatic drive(input int inst, input logic st, input logic s, input logic [31:0] aa,
                       input logic [31:0] bb, input logic ci);
    case (inst)
      0: begin start4 = st; sub4 = s; a4 = aa[3:0]; b4 = bb[3:0]; cin4 = ci; end
      1: begin start8 = st; sub8 = s; a8 = aa[7:0]; b8 = bb[7:0]; cin8 = ci; end
      default: begin start16 = st; sub16 = s; a16 = aa[15:0]; b16 = bb[15:0]; cin16 = ci; end
    endcase
  endtask

  task automatic scramble(input int inst);
    drive(inst, 1'b0, 1'($urandom), $urandom, $urandom, 1'($urandom));
  endtask

  // Full start -> done sequence with latency, busy, hold and result checks.
  task automatic do_op(input int inst, input logic s, input logic [31:0] aa, input logic [31:0] bb,
                       input logic ci);
    logic [31:0] ez, prev_z;
    logic        ec, eo;
    int          n, k, busy_n;
    model(inst, s, aa, bb, ci, ez, ec, eo);
    n   = n_of(inst);
    cur = inst;
    @(negedge clk);
    prev_z = obs_z;
    drive(inst, 1'b1, s, aa, bb, ci);
    @(posedge clk); #1;
    scramble(inst);
    k = 0;
    busy_n = 0;
    while (!obs_done && k < n + 3) begin
      if (obs_busy) busy_n++;
      chk("hold_z", 64'(obs_z), 64'(prev_z));
      @(posedge clk); #1;
      k++;
    end
    chk("latency", 64'(k), 64'(n));
    chk("busy_cycles", 64'(busy_n), 64'(n));
    chk("busy_at_done", 64'(obs_busy), 64'd0);
    chk("z", 64'(obs_z), 64'(ez));
    chk("cout", 64'(obs_cout), 64'(ec));
    chk("ovf", 64'(obs_ovf), 64'(eo));
    @(posedge clk); #1;
    chk("done_pulse", 64'(obs_done), 64'd0);
  endtask

  task automatic exp_res(input logic [31:0] ez, input logic ec, input logic eo);
    chk("dir_z", 64'(obs_z), 64'(ez));
    chk("dir_cout", 64'(obs_cout), 64'(ec));
    chk("dir_ovf", 64'(obs_ovf), 64'(eo));
  endtask

  initial begin
    int k, done_n;
    drive(0, 1'b0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 1'b0, 0, 0, 1'b0);
    drive(2, 1'b0, 1'b0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cur = i;
      #1;
      chk("rst_z", 64'(obs_z), 64'd0);
      chk("rst_busy", 64'(obs_busy), 64'd0);
      chk("rst_done", 64'(obs_done), 64'd0);
      chk("rst_cout", 64'(obs_cout), 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int c = 0; c < 2; c++)
          do_op(0, 1'b0, av, bv, c[0]);

    do_op(1, 1'b0, 32'hFF, 32'h01, 1'b0); exp_res(32'h00, 1'b1, 1'b0);
    do_op(1, 1'b0, 32'h7F, 32'h01, 1'b0); exp_res(32'h80, 1'b0, 1'b1);
    do_op(1, 1'b0, 32'h12, 32'h34, 1'b1); exp_res(32'h47, 1'b0, 1'b0);
    do_op(1, 1'b1, 32'h05, 32'h07, 1'b0); exp_res(32'hFE, 1'b0, 1'b0);
    do_op(1, 1'b1, 32'h80, 32'h01, 1'b0); exp_res(32'h7F, 1'b1, 1'b1);
    do_op(1, 1'b1, 32'h07, 32'h07, 1'b1); exp_res(32'h00, 1'b1, 1'b0);

    // start during RUN is ignored; start in DONE chains the next op
    cur = 1;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h10, 32'h20, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 0, 0, 1'b0);
    k = 0;
    while (!obs_done && k < 8) begin
      if (k == 1) drive(1, 1'b1, 1'b0, 32'h55, 32'h66, 1'b0);
      if (k == 2) drive(1, 1'b0, 1'b0, 0, 0, 1'b0);
      @(posedge clk); #1;
      k++;
    end
    chk("ign_latency", 64'(k), 64'd4);
    chk("ign_z", 64'(obs_z), 64'h30);
    drive(1, 1'b1, 1'b0, 32'h01, 32'h02, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 0, 0, 1'b0);
    k = 0;
    while (!obs_done && k < 8) begin
      chk("b2b_hold", 64'(obs_z), 64'h30);
      chk("b2b_busy", 64'(obs_busy), 64'd1);
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_latency", 64'(k), 64'd4);
    chk("b2b_z", 64'(obs_z), 64'h03);
    @(posedge clk); #1;
    chk("b2b_single_done", 64'(obs_done), 64'd0);

    // asynchronous reset in the middle of an operation
    do_op(1, 1'b0, 32'h12, 32'h34, 1'b1); exp_res(32'h47, 1'b0, 1'b0);
    cur = 1;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'hFF, 32'h01, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 0, 0, 1'b0);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 64'(obs_busy), 64'd0);
    chk("arst_done", 64'(obs_done), 64'd0);
    chk("arst_z", 64'(obs_z), 64'd0);
    chk("arst_cout", 64'(obs_cout), 64'd0);
    chk("arst_ovf", 64'(obs_ovf), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (obs_done || obs_busy) done_n++;
    end
    chk("arst_no_done", 64'(done_n), 64'd0);
    do_op(1, 1'b0, 32'h12, 32'h34, 1'b1); exp_res(32'h47, 1'b0, 1'b0);

    do_op(2, 1'b0, 32'hFFFF, 32'h0000, 1'b1); exp_res(32'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      do_op(1, 1'($urandom), $urandom, $urandom, 1'($urandom));
      do_op(2, 1'($urandom), $urandom, $urandom, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor that processes `STEP` bits per clock through a `STEP`-bit ripple slice built from 1-bit full adders. It is the sequential, width-generic successor to the single-bit full adder: a word-level add/sub unit that trades latency for area. The block is started by a one-cycle request and reports completion with a one-cycle pulse. Results are held until the next operation completes.

## Interface
Parameters:
- `W`, default 32: operand width in bits. Must be ≥ 2 and a multiple of `STEP`.
- `STEP`, default 4: bits processed per cycle. Must be ≥ 1.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `reset_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request. Sampled only when the FSM is in IDLE or DONE.
- `sub`, input, 1: mode. 0 = add, 1 = subtract. Captured with `start`.
- `a`, input, W: operand A. Captured with `start`.
- `b`, input, W: operand B. Captured with `start`.
- `cin`, input, 1: carry-in. Used for add only; ignored when `sub=1`.
- `z`, output, W: result.
- `cout`, output, 1: carry-out. For subtract, `cout=1` means no borrow (a ≥ b unsigned).
- `ovf`, output, 1: two's-complement signed overflow.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE. Let N = W/STEP.
- **IDLE or DONE, with `start=1`:**
  - Capture `a` into a shift register.
  - Capture `b ^ {W{sub}}` into a shift register.
  - Initialise the carry to `sub ? 1 : cin`.
  - Clear the slice counter.
  - Go to RUN.
- **IDLE or DONE, with `start=0`:**
  - DONE goes to IDLE.
  - IDLE stays in IDLE.
- **RUN:** each cycle does the following:
  - Add the low `STEP` bits of both shift registers plus the carry.
  - Shift the sum slice into the result shift register from the MSB side. Shift both operand registers right by `STEP`.
  - Update the carry register.
  - Increment the counter.
  - On the Nth RUN cycle, go to DONE.
- **Entering DONE:**
  - `z` ← assembled result.
  - `cout` ← final carry.
  - `ovf` ← carry-into-MSB XOR carry-out-of-MSB. Capture carry-into-MSB from the last slice.
- **Arithmetic contract:**
  - Add: `{cout,z} = a + b + cin`, computed mod 2^(W+1).
  - Sub: `{cout,z} = a + ~b + 1`.
- **`start` while in RUN:** ignored. Operands are not re-captured and no error is raised.
- **Output hold:** `z`, `cout` and `ovf` update only on entry to DONE. They hold their previous value through IDLE and RUN, including through the next operation until it completes.
- **Back-to-back:** a `start` asserted in the DONE cycle is accepted and RUN begins on the next edge.
- **Reset:** `reset_n` low at any time, including mid-RUN, forces:
  - state IDLE, counter 0, carry 0;
  - `z=0`, `cout=0`, `ovf=0`, `busy=0`, `done=0`;
  - the operation in flight is discarded and no `done` is produced for it.

## Timing
- **Edge numbering:** `start` is sampled high at edge 0.
- **`busy`:** high from just after edge 0 through edge N, i.e. for exactly N cycles.
- **`done`:** high for exactly one cycle, from just after edge N to edge N+1.
- **Results:** `z`, `cout` and `ovf` are valid in the same cycle as `done`.
- **Latency:** N cycles from `start` sampled to `done` high.
- **Maximum throughput:** one operation per N+1 cycles.
- **Registered outputs:** all outputs are registered. There is no combinational path from inputs to outputs.
- **Carry path:** the critical path is the `STEP`-bit ripple slice. `STEP=W` gives a single-cycle RUN (N=1).

## Test plan
- **Exhaustive add (W=4, STEP=1):** run all a, b ∈ 0..15 and cin ∈ {0,1}, each as a full start→done sequence. Required: `{cout,z}` == a+b+cin. `done` arrives exactly 4 cycles after `start`. `busy` is high for 4 cycles.
- **Directed add (W=8, STEP=2):**
  - 0xFF + 0x01, cin=0 → z=0x00, cout=1, ovf=0.
  - 0x7F + 0x01, cin=0 → z=0x80, cout=0, ovf=1.
  - 0x12 + 0x34, cin=1 → z=0x47, cout=0, ovf=0.
- **Directed sub (W=8, STEP=2):**
  - 0x05 − 0x07 → z=0xFE, cout=0, ovf=0.
  - 0x80 − 0x01 → z=0x7F, cout=1, ovf=1.
  - 0x07 − 0x07 with cin=1 → z=0x00, cout=1 (cin ignored).
- **Ignored start (W=8, STEP=2):** start A=0x10 + B=0x20. Pulse `start` with different operands during cycle 2 of RUN. Required: a single `done` at cycle 4, z=0x30, no second operation begins. Then start a back-to-back operation in the DONE cycle. Required: its `done` arrives 4 cycles later and z holds 0x30 until then.
- **Reset mid-operation:** previous result z=0x47. Start 0xFF+0x01 and assert `reset_n`=0 asynchronously at cycle 2. Required: `busy`, `done`, `z`, `cout` and `ovf` all go to 0 immediately, without waiting for a clock edge. No `done` follows after release. A fresh operation then completes normally.
- **Single-cycle mode (W=16, STEP=16):** 0xFFFF + 0x0000, cin=1 → `done` one cycle after `start`, z=0x0000, cout=1, ovf=0.
